// File: rtl/xg_lsu.sv
// xg_lsu: registered, handshaked load/store unit for the xgriscv MEM stage.
// Accepts one access at a time from the pipeline, drives a variable-latency
// data memory port, and returns sign/zero-extended load data or a one-cycle
// misalign pulse.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_*                      access presented by the MEM stage
//   stall                      combinational pipeline hold
//   resp_valid/rdata/rd        load result (one-cycle pulse)
//   misalign/misalign_addr     misaligned or illegal access (one-cycle pulse)
//   mem_req/we/addr/be/wdata   memory request, held until mem_ready
//   mem_ready/mem_rdata        memory completion and read data
module xg_lsu #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ADDR_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [ADDR_SIZE-1:0]   req_addr,
  input  logic [XLEN-1:0]        req_wdata,
  input  logic [4:0]             req_rd,
  output logic                   stall,
  output logic                   resp_valid,
  output logic [XLEN-1:0]        resp_rdata,
  output logic [4:0]             resp_rd,
  output logic                   misalign,
  output logic [ADDR_SIZE-1:0]   misalign_addr,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_SIZE-1:0]   mem_addr,
  output logic [XLEN/8-1:0]      mem_be,
  output logic [XLEN-1:0]        mem_wdata,
  input  logic                   mem_ready,
  input  logic [XLEN-1:0]        mem_rdata
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic                 write_q, write_d;
  logic [4:0]           rd_q, rd_d;
  logic [OFFW-1:0]      off_q, off_d;

  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]        mem_be_q, mem_be_d;
  logic [XLEN-1:0]      mem_wdata_q, mem_wdata_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]      resp_rdata_q, resp_rdata_d;
  logic [4:0]           resp_rd_q, resp_rd_d;
  logic                 misalign_q, misalign_d;
  logic [ADDR_SIZE-1:0] misalign_addr_q, misalign_addr_d;

  // Request decode: legality, lane enables, lane-replicated store data
  logic            req_legal;
  logic [7:0]      base_be;
  logic [NB-1:0]   req_be;
  logic [XLEN-1:0] req_wrep;

  always_comb begin
    req_legal = 1'b1;
    base_be   = 8'h01;
    req_wrep  = req_wdata;
    case (req_size)
      2'b00: begin
        base_be  = 8'h01;
        req_wrep = {NB{req_wdata[7:0]}};
      end
      2'b01: begin
        req_legal = ~req_addr[0];
        base_be   = 8'h03;
        req_wrep  = {(NB/2){req_wdata[15:0]}};
      end
      2'b10: begin
        req_legal = (req_addr[1:0] == 2'b00);
        base_be   = 8'h0F;
        req_wrep  = {(NB/4){req_wdata[31:0]}};
      end
      default: begin
        // double is only legal on a 64-bit datapath
        req_legal = (XLEN == 64) && (req_addr[2:0] == 3'b000);
        base_be   = 8'hFF;
        req_wrep  = req_wdata;
      end
    endcase
    req_be = NB'(base_be) << req_addr[OFFW-1:0];
  end

  // Load extraction: move the addressed lane to bit 0, then push the field
  // to the top and shift back down (arithmetic for signed loads).
  logic [XLEN-1:0] ld_shift, ld_left, ld_ext;
  logic [6:0]      ld_sh;

  always_comb begin
    ld_shift = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ld_sh = 7'(XLEN - 8);
      2'b01:   ld_sh = 7'(XLEN - 16);
      2'b10:   ld_sh = 7'(XLEN - 32);
      default: ld_sh = 7'd0;
    endcase
    ld_left = ld_shift << ld_sh;
    if (uns_q) begin
      ld_ext = ld_left >> ld_sh;
    end else begin
      ld_ext = $signed(ld_left) >>> ld_sh;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    size_d          = size_q;
    uns_d           = uns_q;
    write_d         = write_q;
    rd_d            = rd_q;
    off_d           = off_q;
    mem_req_d       = 1'b0;
    mem_we_d        = 1'b0;
    mem_addr_d      = '0;
    mem_be_d        = '0;
    mem_wdata_d     = '0;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = '0;
    resp_rd_d       = '0;
    misalign_d      = 1'b0;
    misalign_addr_d = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d  = req_size;
          uns_d   = req_unsigned;
          write_d = req_write;
          rd_d    = req_rd;
          off_d   = req_addr[OFFW-1:0];
          if (req_legal) begin
            state_d     = BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = req_write;
            mem_addr_d  = req_addr & ~ADDR_SIZE'(NB - 1);
            mem_be_d    = req_be;
            mem_wdata_d = req_wrep;
          end else begin
            state_d         = FAULT;
            misalign_d      = 1'b1;
            misalign_addr_d = req_addr;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d = DONE;
          if (!write_q) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = ld_ext;
            resp_rd_d    = rd_q;
          end
        end else begin
          // memory port held stable until the completing cycle
          mem_req_d   = 1'b1;
          mem_we_d    = mem_we_q;
          mem_addr_d  = mem_addr_q;
          mem_be_d    = mem_be_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      size_q          <= 2'b00;
      uns_q           <= 1'b0;
      write_q         <= 1'b0;
      rd_q            <= '0;
      off_q           <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_be_q        <= '0;
      mem_wdata_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_rd_q       <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      size_q          <= size_d;
      uns_q           <= uns_d;
      write_q         <= write_d;
      rd_q            <= rd_d;
      off_q           <= off_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_be_q        <= mem_be_d;
      mem_wdata_q     <= mem_wdata_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_rd_q       <= resp_rd_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  // Stall must react in the accepting cycle, so it is decoded combinationally
  assign stall         = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_rd       = resp_rd_q;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_xg_lsu.sv
// tb_xg_lsu: self-checking bench for xg_lsu, one XLEN=32 and one XLEN=64
// instance. A byte-lane model predicts every output each cycle; literal
// values pin the model on the directed cases.
module tb_xg_lsu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // stimulus (index 0 = XLEN 32 instance, index 1 = XLEN 64 instance)
  logic [1:0]       req_valid, req_write, req_unsigned, mem_ready;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_addr;
  logic [1:0][4:0]  req_rd;
  logic [31:0]      w32, r32;
  logic [63:0]      w64, r64;

  // DUT outputs
  wire [1:0]        o_stall, o_rv, o_mis, o_req, o_we;
  wire [1:0][4:0]   o_rd;
  wire [1:0][31:0]  o_misaddr, o_maddr;
  wire [31:0]       d0_rdata, d0_wdata;
  wire [3:0]        d0_be;
  wire [63:0]       d1_rdata, d1_wdata;
  wire [7:0]        d1_be;

  xg_lsu #(.XLEN(32), .ADDR_SIZE(32)) dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_write(req_write[0]), .req_size(req_size[0]),
    .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]), .req_wdata(w32),
    .req_rd(req_rd[0]), .stall(o_stall[0]), .resp_valid(o_rv[0]),
    .resp_rdata(d0_rdata), .resp_rd(o_rd[0]), .misalign(o_mis[0]),
    .misalign_addr(o_misaddr[0]), .mem_req(o_req[0]), .mem_we(o_we[0]),
    .mem_addr(o_maddr[0]), .mem_be(d0_be), .mem_wdata(d0_wdata),
    .mem_ready(mem_ready[0]), .mem_rdata(r32)
  );

  xg_lsu #(.XLEN(64), .ADDR_SIZE(32)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_write(req_write[1]), .req_size(req_size[1]),
    .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]), .req_wdata(w64),
    .req_rd(req_rd[1]), .stall(o_stall[1]), .resp_valid(o_rv[1]),
    .resp_rdata(d1_rdata), .resp_rd(o_rd[1]), .misalign(o_mis[1]),
    .misalign_addr(o_misaddr[1]), .mem_req(o_req[1]), .mem_we(o_we[1]),
    .mem_addr(o_maddr[1]), .mem_be(d1_be), .mem_wdata(d1_wdata),
    .mem_ready(mem_ready[1]), .mem_rdata(r64)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // expected outputs for the current cycle
  logic [1:0]       e_stall, e_req, e_we, e_rv, e_mis;
  logic [1:0][31:0] e_maddr, e_misaddr;
  logic [1:0][63:0] e_wdata, e_rdata;
  logic [1:0][7:0]  e_be;
  logic [1:0][4:0]  e_rd;

  // last observed values within an access
  int          obs_req_cnt, obs_rv_cnt, obs_mis_cnt;
  logic [31:0] obs_maddr, obs_misaddr;
  logic [7:0]  obs_be;
  logic [63:0] obs_wd, obs_rdata;
  logic [4:0]  obs_rd;
  logic        obs_we;

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h, want %h", nm, i, act, exp);
    end
  endtask

  function automatic logic [7:0] act_be(input int i);
    return (i == 0) ? {4'b0, d0_be} : d1_be;
  endfunction
  function automatic logic [63:0] act_wd(input int i);
    return (i == 0) ? {32'b0, d0_wdata} : d1_wdata;
  endfunction
  function automatic logic [63:0] act_rdata(input int i);
    return (i == 0) ? {32'b0, d0_rdata} : d1_rdata;
  endfunction

  // ---------------- byte-lane model ----------------
  function automatic bit m_legal(input int xl, input logic [1:0] sz, input logic [31:0] a);
    int nby = 1 << sz;
    int lo  = int'(a[7:0]);
    if (sz == 2'b11 && xl == 32) return 1'b0;
    return (lo % nby) == 0;
  endfunction

  function automatic logic [31:0] m_maddr(input int xl, input logic [31:0] a);
    int off = int'(a[7:0]) % (xl / 8);
    return a - 32'(off);
  endfunction

  function automatic logic [7:0] m_be(input int xl, input logic [1:0] sz, input logic [31:0] a);
    int nby = 1 << sz;
    int off = int'(a[7:0]) % (xl / 8);
    logic [7:0] be = '0;
    for (int j = 0; j < xl / 8; j++) be[j] = (j >= off) && (j < off + nby);
    return be;
  endfunction

  function automatic logic [63:0] m_wdata(input int xl, input logic [1:0] sz, input logic [63:0] wd);
    int nby = 1 << sz;
    logic [63:0] res = '0;
    for (int j = 0; j < xl / 8; j++) res[j*8 +: 8] = wd[(j % nby)*8 +: 8];
    return res;
  endfunction

  function automatic logic [63:0] m_load(input int xl, input logic [1:0] sz, input bit uns,
                                         input logic [31:0] a, input logic [63:0] rdat);
    int nby = 1 << sz;
    int off = int'(a[7:0]) % (xl / 8);
    logic [63:0] v = '0;
    for (int b = 0; b < nby; b++) v[b*8 +: 8] = rdat[(off + b)*8 +: 8];
    if (!uns && v[nby*8-1]) for (int t = nby * 8; t < xl; t++) v[t] = 1'b1;
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk("stall", i, 64'(o_stall[i]), 64'(e_stall[i]));
        chk("mem_req", i, 64'(o_req[i]), 64'(e_req[i]));
        chk("resp_valid", i, 64'(o_rv[i]), 64'(e_rv[i]));
        chk("misalign", i, 64'(o_mis[i]), 64'(e_mis[i]));
        if (e_req[i]) begin
          chk("mem_we", i, 64'(o_we[i]), 64'(e_we[i]));
          chk("mem_addr", i, 64'(o_maddr[i]), 64'(e_maddr[i]));
          chk("mem_be", i, 64'(act_be(i)), 64'(e_be[i]));
          chk("mem_wdata", i, act_wd(i), e_wdata[i]);
        end
        if (e_rv[i]) begin
          chk("resp_rdata", i, act_rdata(i), e_rdata[i]);
          chk("resp_rd", i, 64'(o_rd[i]), 64'(e_rd[i]));
        end
        if (e_mis[i]) chk("misalign_addr", i, 64'(o_misaddr[i]), 64'(e_misaddr[i]));
      end
    end
  end

  task automatic exp_clear();
    e_stall = '0; e_req = '0; e_we = '0; e_rv = '0; e_mis = '0;
    e_maddr = '0; e_misaddr = '0; e_wdata = '0; e_rdata = '0; e_be = '0; e_rd = '0;
  endtask

  task automatic set_rdata(input int i, input logic [63:0] v);
    if (i == 0) r32 = v[31:0];
    else r64 = v;
  endtask

  // one cycle: observe at negedge, then step past the next posedge
  task automatic sample(input int i);
    @(negedge clk);
    obs_req_cnt += int'(o_req[i]);
    obs_rv_cnt  += int'(o_rv[i]);
    obs_mis_cnt += int'(o_mis[i]);
    if (o_req[i]) begin
      obs_maddr = o_maddr[i]; obs_be = act_be(i); obs_wd = act_wd(i); obs_we = o_we[i];
    end
    if (o_rv[i]) begin
      obs_rdata = act_rdata(i); obs_rd = o_rd[i];
    end
    if (o_mis[i]) obs_misaddr = o_misaddr[i];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    exp_clear();
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  // One access on instance i; mem_ready on the k-th BUSY cycle; if rst_at
  // is nonzero, reset is asserted during that BUSY cycle instead.
  task automatic access(input int i, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [63:0] wd, input logic [4:0] rd,
                        input logic [63:0] rdat, input int k, input int rst_at);
    int xl;
    bit legal;
    bit aborted;
    xl = (i == 0) ? 32 : 64;
    legal = m_legal(xl, sz, a);
    aborted = 1'b0;
    obs_req_cnt = 0; obs_rv_cnt = 0; obs_mis_cnt = 0;
    obs_maddr = 'x; obs_misaddr = 'x; obs_be = 'x; obs_wd = 'x; obs_rdata = 'x;
    obs_rd = 'x; obs_we = 1'bx;
    req_valid[i] = 1'b1; req_write[i] = wr; req_size[i] = sz;
    req_unsigned[i] = uns; req_addr[i] = a; req_rd[i] = rd;
    if (i == 0) w32 = wd[31:0];
    else w64 = wd;
    exp_clear();
    e_stall[i] = 1'b1;
    sample(i);
    req_valid[i] = 1'b0;
    if (!legal) begin
      exp_clear();
      e_mis[i] = 1'b1;
      e_misaddr[i] = a;
      sample(i);
      exp_clear();
    end else begin
      for (int j = 1; j <= k && !aborted; j++) begin
        exp_clear();
        e_stall[i] = 1'b1; e_req[i] = 1'b1; e_we[i] = wr;
        e_maddr[i] = m_maddr(xl, a); e_be[i] = m_be(xl, sz, a);
        e_wdata[i] = m_wdata(xl, sz, wd);
        mem_ready[i] = (j == k);
        set_rdata(i, (j == k) ? rdat : ~rdat);
        if (j == rst_at) reset = 1'b1;
        sample(i);
        mem_ready[i] = 1'b0;
        if (j == rst_at) begin
          reset = 1'b0;
          aborted = 1'b1;
        end
      end
      exp_clear();
      if (!aborted) begin
        e_rv[i] = !wr;
        e_rdata[i] = m_load(xl, sz, uns, a, rdat);
        e_rd[i] = rd;
        sample(i);
        exp_clear();
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_unsigned = '0; mem_ready = '0;
    req_size = '0; req_addr = '0; req_rd = '0;
    w32 = '0; r32 = '0; w64 = '0; r64 = '0;
    exp_clear();
    repeat (3) @(posedge clk);
    #1;

    // reset state: everything zero on both widths
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_stall", i, 64'(o_stall[i]), 64'd0);
      chk("rst_mem_req", i, 64'(o_req[i]), 64'd0);
      chk("rst_mem_we", i, 64'(o_we[i]), 64'd0);
      chk("rst_mem_addr", i, 64'(o_maddr[i]), 64'd0);
      chk("rst_mem_be", i, 64'(act_be(i)), 64'd0);
      chk("rst_mem_wdata", i, act_wd(i), 64'd0);
      chk("rst_resp_valid", i, 64'(o_rv[i]), 64'd0);
      chk("rst_resp_rdata", i, act_rdata(i), 64'd0);
      chk("rst_resp_rd", i, 64'(o_rd[i]), 64'd0);
      chk("rst_misalign", i, 64'(o_mis[i]), 64'd0);
      chk("rst_misalign_addr", i, 64'(o_misaddr[i]), 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_on = 1'b1;
    idle(1);

    // model pins
    chk("pin_model_lh", 0, m_load(32, 2'b01, 1'b0, 32'h2002, 64'h80011234), 64'hFFFF8001);
    chk("pin_model_be64", 1, 64'(m_be(64, 2'b10, 32'h0C)), 64'hF0);

    // XLEN=32 sb 0x1003
    access(0, 1'b1, 2'b00, 1'b0, 32'h1003, 64'hAB, 5'd0, 64'h0, 1, 0);
    chk("sb_addr", 0, 64'(obs_maddr), 64'h1000);
    chk("sb_be", 0, 64'(obs_be), 64'h8);
    chk("sb_wdata", 0, obs_wd, 64'hABABABAB);
    chk("sb_we", 0, 64'(obs_we), 64'd1);
    chk("sb_no_resp", 0, 64'(obs_rv_cnt), 64'd0);
    idle(1);

    // lh / lhu 0x2002
    access(0, 1'b0, 2'b01, 1'b0, 32'h2002, 64'h0, 5'd5, 64'h80011234, 1, 0);
    chk("lh_rdata", 0, obs_rdata, 64'hFFFF8001);
    chk("lh_rd", 0, 64'(obs_rd), 64'd5);
    idle(1);
    access(0, 1'b0, 2'b01, 1'b1, 32'h2002, 64'h0, 5'd5, 64'h80011234, 1, 0);
    chk("lhu_rdata", 0, obs_rdata, 64'h00008001);
    idle(1);

    // wait states
    access(0, 1'b0, 2'b10, 1'b0, 32'h3000, 64'h0, 5'd7, 64'hDEADBEEF, 4, 0);
    chk("ws_req_cycles", 0, 64'(obs_req_cnt), 64'd4);
    chk("ws_resp_pulses", 0, 64'(obs_rv_cnt), 64'd1);
    chk("ws_rdata", 0, obs_rdata, 64'hDEADBEEF);
    idle(1);

    // misaligned lw, illegal ld on 32-bit
    access(0, 1'b0, 2'b10, 1'b0, 32'h1002, 64'h0, 5'd1, 64'h0, 1, 0);
    chk("mis_addr", 0, 64'(obs_misaddr), 64'h1002);
    chk("mis_no_req", 0, 64'(obs_req_cnt), 64'd0);
    chk("mis_pulses", 0, 64'(obs_mis_cnt), 64'd1);
    idle(1);
    access(0, 1'b0, 2'b11, 1'b0, 32'h0, 64'h0, 5'd2, 64'h0, 1, 0);
    chk("ld32_pulses", 0, 64'(obs_mis_cnt), 64'd1);
    chk("ld32_no_req", 0, 64'(obs_req_cnt), 64'd0);
    idle(1);

    // sh 0x1006, lbu/lb 0x4001
    access(0, 1'b1, 2'b01, 1'b0, 32'h1006, 64'h1234, 5'd0, 64'h0, 2, 0);
    chk("sh_be", 0, 64'(obs_be), 64'hC);
    chk("sh_wdata", 0, obs_wd, 64'h12341234);
    chk("sh_addr", 0, 64'(obs_maddr), 64'h1004);
    idle(1);
    access(0, 1'b0, 2'b00, 1'b1, 32'h4001, 64'h0, 5'd9, 64'h0000F100, 1, 0);
    chk("lbu_rdata", 0, obs_rdata, 64'hF1);
    access(0, 1'b0, 2'b00, 1'b0, 32'h4001, 64'h0, 5'd9, 64'h0000F100, 1, 0);
    chk("lb_rdata", 0, obs_rdata, 64'hFFFFFFF1);
    idle(1);

    // reset mid-access, then a normal access
    access(0, 1'b0, 2'b10, 1'b0, 32'h5000, 64'h0, 5'd3, 64'h11223344, 5, 2);
    idle(3);
    chk("rst_abort_no_resp", 0, 64'(obs_rv_cnt), 64'd0);
    access(0, 1'b0, 2'b10, 1'b0, 32'h5004, 64'h0, 5'd4, 64'h55667788, 1, 0);
    chk("post_rst_rdata", 0, obs_rdata, 64'h55667788);
    chk("post_rst_rd", 0, 64'(obs_rd), 64'd4);

    // mem_ready outside BUSY is ignored
    mem_ready = 2'b11;
    r32 = 32'hA5A5A5A5;
    r64 = 64'hA5A5A5A5A5A5A5A5;
    idle(2);
    mem_ready = 2'b00;
    idle(1);

    // XLEN=64
    access(1, 1'b0, 2'b10, 1'b0, 32'h0C, 64'h0, 5'd11, 64'h9000000011112222, 1, 0);
    chk("lw64_addr", 1, 64'(obs_maddr), 64'h08);
    chk("lw64_be", 1, 64'(obs_be), 64'hF0);
    chk("lw64_rdata", 1, obs_rdata, 64'hFFFFFFFF90000000);
    idle(1);
    access(1, 1'b0, 2'b10, 1'b1, 32'h0C, 64'h0, 5'd11, 64'h9000000011112222, 1, 0);
    chk("lwu64_rdata", 1, obs_rdata, 64'h0000000090000000);
    access(1, 1'b0, 2'b11, 1'b1, 32'h10, 64'h0, 5'd12, 64'h0123456789ABCDEF, 2, 0);
    chk("ld64_be", 1, 64'(obs_be), 64'hFF);
    chk("ld64_rdata", 1, obs_rdata, 64'h0123456789ABCDEF);
    idle(1);
    access(1, 1'b1, 2'b10, 1'b0, 32'h14, 64'hCAFEBABE, 5'd0, 64'h0, 1, 0);
    chk("sw64_addr", 1, 64'(obs_maddr), 64'h10);
    chk("sw64_be", 1, 64'(obs_be), 64'hF0);
    chk("sw64_wdata", 1, obs_wd, 64'hCAFEBABECAFEBABE);
    idle(1);
    access(1, 1'b1, 2'b11, 1'b0, 32'h14, 64'h1, 5'd0, 64'h0, 1, 0);
    chk("sd64_mis_addr", 1, 64'(obs_misaddr), 64'h14);
    chk("sd64_no_req", 1, 64'(obs_req_cnt), 64'd0);
    idle(2);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
